// File: rtl/calc_op_sequencer.sv
// Sequenced arithmetic unit: one-cycle add/sub, 7-step shift-add multiply and
// 14-step restoring divide sharing one datapath, with a last-good-result register for chaining.
module calc_op_sequencer #(
    parameter int OPW = 7,
    parameter int RW  = 14
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           clear,
    input  logic [2:0]     func,
    input  logic           chain,
    input  logic [OPW-1:0] op_a,
    input  logic [OPW-1:0] op_b,
    output logic           busy,
    output logic           done,
    output logic [RW-1:0]  result,
    output logic [OPW-1:0] rem,
    output logic [1:0]     err
);
    localparam int MW = RW + OPW;
    localparam int CW = $clog2(RW + 1);

    localparam logic [2:0] F_ADD = 3'b001;
    localparam logic [2:0] F_SUB = 3'b010;
    localparam logic [2:0] F_MUL = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100;

    localparam logic [1:0] E_OK  = 2'b00;
    localparam logic [1:0] E_DBZ = 2'b01;
    localparam logic [1:0] E_UNF = 2'b10;
    localparam logic [1:0] E_OVF = 2'b11;

    localparam logic [CW-1:0] MUL_LAST = CW'(OPW - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(RW - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [2:0]     r_func;
    logic [RW-1:0]  r_a;       // operand A; shifts into the quotient during divide
    logic [OPW-1:0] r_b;       // operand B; shifts right during multiply
    logic [MW-1:0]  r_acc;
    logic [OPW-1:0] r_prem;
    logic [CW-1:0]  r_cnt;
    logic [RW-1:0]  r_last;
    logic [RW-1:0]  r_result;
    logic [OPW-1:0] r_rem;
    logic [1:0]     r_err;
    logic           r_busy;
    logic           r_done;

    logic           w_func_ok;
    logic           w_accept;
    logic           w_fin;
    logic [RW-1:0]  w_res;
    logic [OPW-1:0] w_rem;
    logic [1:0]     w_err;
    logic [MW-1:0]  w_acc_n;
    logic [RW-1:0]  w_a_n;
    logic [OPW-1:0] w_b_n;
    logic [OPW-1:0] w_prem_n;
    logic [RW:0]    w_sum;
    logic [RW-1:0]  w_bext;
    logic [MW-1:0]  w_addend;
    logic [OPW:0]   w_trial;
    logic [OPW-1:0] w_prem_sub;
    logic           w_ge;

    assign w_func_ok  = (func == F_ADD) || (func == F_SUB) || (func == F_MUL) || (func == F_DIV);
    assign w_accept   = (r_state == S_IDLE) && start && !clear && w_func_ok;
    assign w_bext     = {{(RW-OPW){1'b0}}, r_b};
    assign w_sum      = {1'b0, r_a} + {1'b0, w_bext};
    assign w_addend   = r_b[0] ? ({{OPW{1'b0}}, r_a} << r_cnt) : '0;
    // Partial remainder stays below B, so the shifted trial value fits in OPW+1 bits
    assign w_trial    = {r_prem, r_a[RW-1]};
    assign w_ge       = w_trial >= {1'b0, r_b};
    assign w_prem_sub = w_trial[OPW-1:0] - r_b;

    always_comb begin
        w_next   = r_state;
        w_fin    = 1'b0;
        w_res    = '0;
        w_rem    = '0;
        w_err    = E_OK;
        w_acc_n  = r_acc;
        w_a_n    = r_a;
        w_b_n    = r_b;
        w_prem_n = r_prem;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_EXEC;
            S_EXEC: begin
                case (r_func)
                    F_ADD: begin
                        w_fin = 1'b1;
                        w_res = w_sum[RW-1:0];
                        if (w_sum[RW]) w_err = E_OVF;
                    end
                    F_SUB: begin
                        w_fin = 1'b1;
                        if (r_a < w_bext) w_err = E_UNF;
                        else              w_res = r_a - w_bext;
                    end
                    F_MUL: begin
                        w_acc_n = r_acc + w_addend;
                        w_b_n   = r_b >> 1;
                        if (r_cnt == MUL_LAST) begin
                            w_fin = 1'b1;
                            w_res = w_acc_n[RW-1:0];
                            if (|w_acc_n[MW-1:RW]) w_err = E_OVF;
                        end
                    end
                    F_DIV: begin
                        if (r_cnt == '0 && r_b == '0) begin
                            w_fin = 1'b1;
                            w_err = E_DBZ;
                        end else begin
                            w_prem_n = w_ge ? w_prem_sub : w_trial[OPW-1:0];
                            w_a_n    = {r_a[RW-2:0], w_ge};
                            if (r_cnt == DIV_LAST) begin
                                w_fin = 1'b1;
                                w_res = w_a_n;
                                w_rem = w_prem_n;
                            end
                        end
                    end
                    default: w_fin = 1'b1;
                endcase
                if (w_fin) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_func   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_last   <= '0;
            r_result <= '0;
            r_rem    <= '0;
            r_err    <= E_OK;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (clear) begin
            r_state  <= S_IDLE;
            r_last   <= '0;
            r_result <= '0;
            r_rem    <= '0;
            r_err    <= E_OK;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            if (w_accept) begin
                r_func <= func;
                r_a    <= chain ? r_last : {{(RW-OPW){1'b0}}, op_a};
                r_b    <= op_b;
                r_acc  <= '0;
                r_prem <= '0;
                r_cnt  <= '0;
            end else if (r_state == S_EXEC) begin
                r_cnt  <= r_cnt + CW'(1);
                r_acc  <= w_acc_n;
                r_a    <= w_a_n;
                r_b    <= w_b_n;
                r_prem <= w_prem_n;
            end
            if (w_fin) begin
                r_result <= w_res;
                r_rem    <= w_rem;
                r_err    <= w_err;
                if (w_err == E_OK) r_last <= w_res;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign rem    = r_rem;
    assign err    = r_err;
endmodule
